// File: rtl/reg_arb_pkg.sv
// Shared types and defaults for the register-bus arbiter.
// Nothing here depends on REG_ARB_LOCK_EN.
package reg_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // Command bundle at the default widths.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [BE_W_DEF-1:0]   be;
    logic [DATA_W_DEF-1:0] wdata;
  } reg_cmd_t;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester-side and register-file-side signals of reg_bus_arbiter.
// slave is the arbiter's view; master is the view of its environment.
interface reg_bus_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ-1:0]        i_we;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ*BE_W-1:0]   i_be;
  logic [NUM_REQ*DATA_W-1:0] i_wdata;
  logic [NUM_REQ-1:0]        i_lock;
  logic [NUM_REQ-1:0]        o_gnt;
  logic [NUM_REQ-1:0]        o_rvalid;
  logic [DATA_W-1:0]         o_rdata;
  logic                      o_req;
  logic                      o_we;
  logic [ADDR_W-1:0]         o_addr;
  logic [BE_W-1:0]           o_be;
  logic [DATA_W-1:0]         o_wdata;
  logic [DATA_W-1:0]         i_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_be, i_wdata, i_lock, i_rdata,
    output o_gnt, o_rvalid, o_rdata, o_req, o_we, o_addr, o_be, o_wdata
  );

  modport master (
    output i_req, i_we, i_addr, i_be, i_wdata, i_lock, i_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_req, o_we, o_addr, o_be, o_wdata
  );

endinterface

// File: rtl/reg_arb_rr.sv
// Combinational rotating-priority find-first: lowest eligible index at or
// above ptr, wrapping. Winner is one-hot; valid when any requester is eligible.
module reg_arb_rr #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;

  // Rotate so bit 0 is the pointer position, isolate the lowest set bit,
  // then rotate back.
  assign rot    = N'({eligible, eligible} >> ptr);
  assign rot_oh = rot & (~rot + ONE);
  assign winner = N'(({rot_oh, rot_oh} << ptr) >> N);
  assign valid  = |eligible;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-file port among NUM_REQ requesters.
// Define REG_ARB_LOCK_EN to let a requester hold ownership across accesses.
module reg_bus_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input logic              clk,
  input logic              rst,
  reg_bus_arbiter_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t               req_cmd [NUM_REQ];
  cmd_t               cmd_q, cmd_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_cmd[gi] = '{
      we:    bus.i_we[gi],
      addr:  bus.i_addr[gi*ADDR_W +: ADDR_W],
      be:    bus.i_be[gi*BE_W +: BE_W],
      wdata: bus.i_wdata[gi*DATA_W +: DATA_W]
    };
  end

`ifdef REG_ARB_LOCK_EN
  logic               owner_valid_q, owner_valid_d;
  logic [NUM_REQ-1:0] owner_q, owner_d;

  // A held grant masks its requester; an owner excludes everyone else.
  always_comb begin
    eligible = bus.i_req & ~gnt_q;
    if (owner_valid_q) begin
      eligible = eligible & owner_q;
    end
    owner_valid_d = owner_valid_q;
    owner_d       = owner_q;
    if (win_valid) begin
      owner_valid_d = bus.i_lock[win_idx];
      owner_d       = bus.i_lock[win_idx] ? win_oh : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_valid_q <= 1'b0;
      owner_q       <= '0;
    end else begin
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
    end
  end
`else
  assign eligible = bus.i_req & ~gnt_q;
`endif

  reg_arb_rr #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (win_oh),
    .valid    (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_oh[k]) begin
        win_idx = PTR_W'(k);
      end
    end
  end

  always_comb begin
    gnt_d    = win_oh;
    rvalid_d = gnt_q;
    ptr_d    = ptr_q;
    cmd_d    = '0;
    if (win_valid) begin
      ptr_d = PTR_W'(rr_next(32'(win_idx), NUM_REQ));
      cmd_d = req_cmd[win_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      ptr_q    <= '0;
      cmd_q    <= '0;
    end else begin
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      ptr_q    <= ptr_d;
      cmd_q    <= cmd_d;
    end
  end

  assign bus.o_gnt    = gnt_q;
  assign bus.o_req    = |gnt_q;
  assign bus.o_we     = cmd_q.we;
  assign bus.o_addr   = cmd_q.addr;
  assign bus.o_be     = cmd_q.be;
  assign bus.o_wdata  = cmd_q.wdata;
  assign bus.o_rvalid = rvalid_q;
  // Register-file data arrives the cycle after o_req, aligned with o_rvalid.
  assign bus.o_rdata  = (|rvalid_q) ? bus.i_rdata : '0;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: protocol-following requesters, a
// behavioural arbitration model filling expectation queues, and a monitor.
module tb_reg_bus_arbiter;
  import reg_arb_pkg::*;

  localparam int N  = 3;
  localparam int AW = ADDR_W_DEF;
  localparam int DW = DATA_W_DEF;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bus_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  reg_bus_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    reg_cmd_t cmd;
    logic     lock;
    int       idle;
  } tb_cmd_t;

  typedef struct {
    int       cyc;
    int       idx;
    reg_cmd_t cmd;
  } exp_t;

  tb_cmd_t      cmdq [N][$];
  exp_t         gnt_exp[$];
  exp_t         rsp_exp[$];
  int           log_idx[$];
  int           log_cyc[$];
  int           idle_cnt [N];
  int           cyc    = 0;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  logic [N-1:0] d1 = '0;
  logic [N-1:0] d2 = '0;
  int           m_ptr = 0;
  int           owner = -1;
  logic [DW-1:0] cur_rdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic tb_cmd_t mk(input logic we, input logic [AW-1:0] addr,
                                 input logic [BW-1:0] be, input logic [DW-1:0] wd,
                                 input logic lock, input int idle);
    tb_cmd_t c;
    c.cmd.we    = we;
    c.cmd.addr  = addr;
    c.cmd.be    = be;
    c.cmd.wdata = wd;
    c.lock      = lock;
    c.idle      = idle;
    return c;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock of requesters plus the reference model of the arbitration rules.
  task automatic step(input bit do_rst);
    logic [N-1:0] req_v;
    logic [N-1:0] lock_v;
    logic [N-1:0] elig;
    logic [N-1:0] d0;
    int           win;
    exp_t         e;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (d2[k] && cmdq[k].size() > 0) begin
        void'(cmdq[k].pop_front());
        idle_cnt[k] = (cmdq[k].size() > 0) ? cmdq[k][0].idle : 0;
      end
      req_v[k] = (cmdq[k].size() > 0) && (idle_cnt[k] == 0);
      if (!req_v[k] && idle_cnt[k] > 0) idle_cnt[k]--;
      lock_v[k] = req_v[k] ? cmdq[k][0].lock : 1'b0;
      bus.i_we[k]                = req_v[k] ? cmdq[k][0].cmd.we : 1'b0;
      bus.i_addr[k*AW +: AW]     = req_v[k] ? cmdq[k][0].cmd.addr : '0;
      bus.i_be[k*BW +: BW]       = req_v[k] ? cmdq[k][0].cmd.be : '0;
      bus.i_wdata[k*DW +: DW]    = req_v[k] ? cmdq[k][0].cmd.wdata : '0;
    end
    bus.i_req  = req_v;
    bus.i_lock = lock_v;
    cur_rdata  = {$urandom, $urandom};
    bus.i_rdata = cur_rdata;
    rst = do_rst;
    if (do_rst) begin
      d1 = '0;
      d2 = '0;
      m_ptr = 0;
      owner = -1;
      while (gnt_exp.size() > 0 && gnt_exp[$].cyc > cyc) void'(gnt_exp.pop_back());
      while (rsp_exp.size() > 0 && rsp_exp[$].cyc > cyc) void'(rsp_exp.pop_back());
    end else begin
      elig = req_v & ~d1;
`ifdef REG_ARB_LOCK_EN
      if (owner >= 0) elig = elig & (N'(1) << owner);
`endif
      d0  = '0;
      win = -1;
      for (int i = 0; i < N; i++) begin
        if (win < 0 && elig[(m_ptr + i) % N]) win = (m_ptr + i) % N;
      end
      if (win >= 0) begin
        d0[win] = 1'b1;
        e.cyc = cyc + 1;
        e.idx = win;
        e.cmd = cmdq[win][0].cmd;
        gnt_exp.push_back(e);
        e.cyc = cyc + 2;
        rsp_exp.push_back(e);
        m_ptr = (win + 1) % N;
`ifdef REG_ARB_LOCK_EN
        owner = lock_v[win] ? win : -1;
`endif
      end
      d2 = d1;
      d1 = d0;
    end
  endtask

  task automatic run_idle(input int max_cycles);
    int n = 0;
    bit done = 1'b0;
    do begin
      step(1'b0);
      n++;
      done = (gnt_exp.size() == 0) && (rsp_exp.size() == 0) && (d1 == '0) && (d2 == '0);
      for (int k = 0; k < N; k++) if (cmdq[k].size() > 0) done = 1'b0;
    end while (!done && n < max_cycles);
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  // Monitor: pops expectations whenever the DUT presents a grant or response.
  exp_t mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      while (gnt_exp.size() > 0 && gnt_exp[0].cyc < cyc) begin
        chk("gnt_missing", 64'hFFFF, 64'(gnt_exp[0].idx));
        void'(gnt_exp.pop_front());
      end
      while (rsp_exp.size() > 0 && rsp_exp[0].cyc < cyc) begin
        chk("rsp_missing", 64'hFFFF, 64'(rsp_exp[0].idx));
        void'(rsp_exp.pop_front());
      end
      if (bus.o_req) begin
        if (gnt_exp.size() > 0 && gnt_exp[0].cyc == cyc) begin
          mon_e = gnt_exp.pop_front();
          chk("gnt", 64'(bus.o_gnt), 64'(1) << mon_e.idx);
          chk("we", 64'(bus.o_we), 64'(mon_e.cmd.we));
          chk("addr", 64'(bus.o_addr), 64'(mon_e.cmd.addr));
          chk("be", 64'(bus.o_be), 64'(mon_e.cmd.be));
          chk("wdata", bus.o_wdata, mon_e.cmd.wdata);
          $display("GNT cyc=%0d req=%0d we=%0b addr=%h be=%h wdata=%h",
                   cyc, oh_idx(bus.o_gnt), bus.o_we, bus.o_addr, bus.o_be, bus.o_wdata);
          log_idx.push_back(oh_idx(bus.o_gnt));
          log_cyc.push_back(cyc);
        end else begin
          chk("req_unexpected", 64'(bus.o_req), 64'd0);
        end
      end else begin
        chk("gnt_idle", 64'(bus.o_gnt), 64'd0);
      end
      if (|bus.o_rvalid) begin
        if (rsp_exp.size() > 0 && rsp_exp[0].cyc == cyc) begin
          mon_e = rsp_exp.pop_front();
          chk("rvalid", 64'(bus.o_rvalid), 64'(1) << mon_e.idx);
          if (!mon_e.cmd.we) chk("rdata", bus.o_rdata, cur_rdata);
          $display("RSP cyc=%0d req=%0d rdata=%h", cyc, oh_idx(bus.o_rvalid), bus.o_rdata);
        end else begin
          chk("rvalid_unexpected", 64'(bus.o_rvalid), 64'd0);
        end
      end
    end
  end

  initial begin
    int t0;
    for (int k = 0; k < N; k++) idle_cnt[k] = 0;
    bus.i_req = '0; bus.i_we = '0; bus.i_addr = '0; bus.i_be = '0;
    bus.i_wdata = '0; bus.i_lock = '0; bus.i_rdata = '0;
    step(1'b1);
    step(1'b1);
    @(negedge clk);
    chk("rst_gnt", 64'(bus.o_gnt), 64'd0);
    chk("rst_rvalid", 64'(bus.o_rvalid), 64'd0);
    chk("rst_req", 64'(bus.o_req), 64'd0);
    chk("rst_we", 64'(bus.o_we), 64'd0);
    chk("rst_addr", 64'(bus.o_addr), 64'd0);
    chk("rst_be", 64'(bus.o_be), 64'd0);
    chk("rst_wdata", bus.o_wdata, 64'd0);
    chk("rst_rdata", bus.o_rdata, 64'd0);
    mon_en = 1'b1;

    // Single read from requester 0 at address 0.
    log_idx.delete(); log_cyc.delete();
    cmdq[0].push_back(mk(1'b0, '0, 8'hFF, '0, 1'b0, 0));
    t0 = cyc + 1;
    run_idle(20);
    chk("single_cnt", 64'(log_idx.size()), 64'd1);
    if (log_idx.size() == 1) begin
      chk("single_idx", 64'(log_idx[0]), 64'd0);
      chk("single_lat", 64'(log_cyc[0]), 64'(t0 + 1));
    end

    // Requesters 0 and 1 continuously: back-to-back alternating grants.
    log_idx.delete(); log_cyc.delete();
    for (int i = 0; i < 6; i++) begin
      cmdq[0].push_back(mk(1'b0, $urandom, 8'hFF, '0, 1'b0, 0));
      cmdq[1].push_back(mk(1'b1, $urandom, $urandom, {$urandom, $urandom}, 1'b0, 0));
    end
    run_idle(60);
    chk("alt_cnt", 64'(log_idx.size()), 64'd12);
    for (int i = 1; i < log_idx.size(); i++) begin
      chk("alt_idx", 64'(log_idx[i]), 64'(1 - log_idx[i-1]));
      chk("alt_cyc", 64'(log_cyc[i]), 64'(log_cyc[i-1] + 1));
    end

    // Requester 1 alone: four writes, one grant every other cycle.
    log_idx.delete(); log_cyc.delete();
    for (int i = 0; i < 4; i++)
      cmdq[1].push_back(mk(1'b1, 32'h100 + 32'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b0, 0));
    t0 = cyc + 1;
    run_idle(40);
    chk("solo_cnt", 64'(log_idx.size()), 64'd4);
    for (int i = 0; i < log_idx.size(); i++) begin
      chk("solo_idx", 64'(log_idx[i]), 64'd1);
      chk("solo_cyc", 64'(log_cyc[i]), 64'(t0 + 1 + 2 * i));
    end

    // Random traffic from all requesters with random idle gaps.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 40; i++)
        cmdq[k].push_back(mk(1'($urandom), $urandom, $urandom, {$urandom, $urandom},
                             1'b0, $urandom_range(0, 3)));
    run_idle(1000);

`ifdef REG_ARB_LOCK_EN
    // Requester 1 locks for two accesses while requester 0 waits.
    log_idx.delete(); log_cyc.delete();
    cmdq[1].push_back(mk(1'b1, 32'h40, 8'h0F, {$urandom, $urandom}, 1'b1, 0));
    cmdq[1].push_back(mk(1'b1, 32'h44, 8'hF0, {$urandom, $urandom}, 1'b0, 0));
    cmdq[0].push_back(mk(1'b0, 32'h08, 8'hFF, '0, 1'b0, 0));
    cmdq[0].push_back(mk(1'b0, 32'h10, 8'hFF, '0, 1'b0, 0));
    idle_cnt[0] = 1;
    run_idle(40);
    chk("lock_cnt", 64'(log_idx.size()), 64'd4);
    if (log_idx.size() == 4) begin
      chk("lock_first", 64'(log_idx[0]), 64'd1);
      chk("lock_second", 64'(log_idx[1]), 64'd1);
      chk("lock_third", 64'(log_idx[2]), 64'd0);
    end
`endif

    // Reset asserted in a cycle where a grant is visible.
    for (int i = 0; i < 8; i++) begin
      cmdq[0].push_back(mk(1'b0, $urandom, 8'hFF, '0, 1'b0, 0));
      cmdq[1].push_back(mk(1'b0, $urandom, 8'hFF, '0, 1'b0, 0));
    end
    repeat (5) step(1'b0);
    chk("pre_rst_gnt_pending", 64'(d1 != '0), 64'd1);
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    chk("midrst_req", 64'(bus.o_req), 64'd0);
    chk("midrst_rvalid", 64'(bus.o_rvalid), 64'd0);
    log_idx.delete(); log_cyc.delete();
    run_idle(100);
    if (log_idx.size() > 0) chk("midrst_first", 64'(log_idx[0]), 64'd0);
    else chk("midrst_first_cnt", 64'd0, 64'd1);

    step(1'b0);
    step(1'b0);
    chk("gnt_left", 64'(gnt_exp.size()), 64'd0);
    chk("rsp_left", 64'(rsp_exp.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
